// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb_pkg
// Purpose  : Shared constants for the shared-ALU arbiter: sequencer state
//            encodings, ALU opcode values and the undefined-opcode lookup.
// Revision : 1.0 - initial release
// ============================================================================
package alu_share_arb_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // ALU opcodes (3, 4, 13, 14 and 15 are unassigned)
    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRA  = 4'd1;
    localparam logic [3:0] OP_SRL  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_SLTU = 4'd12;

    // Bit n set means opcode n is undefined: bits 3, 4, 13, 14, 15
    localparam logic [15:0] UNDEF_OP_MASK = 16'hE018;

    function automatic logic is_undef_op(input logic [3:0] op);
        return UNDEF_OP_MASK[op];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb_rr_arb2
// Purpose  : Combinational two-way round-robin grant.
//   en         in   grant permitted this cycle
//   req_valid  in   [1:0] request per requester
//   rr_ptr     in   requester favoured when both request
//   grant      out  [1:0] one-hot or zero grant
//   grant_idx  out  index of the granted requester (valid when |grant)
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb_rr_arb2 (
    input  logic       en,
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       grant_idx
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (&req_valid) begin
                grant = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign grant_idx = grant[1];

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb
// Purpose  : Time-shares one external combinational ALU between two
//            requesters. One operation in flight at a time:
//            IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold response).
//   req_valid/req_ready   [1:0] per-requester issue handshake
//   req{0,1}_a/_b/_op     requester operands and opcode
//   rsp_valid/rsp_ready   [1:0] per-requester response handshake
//   rsp_result/e/ge/err   captured ALU outputs, err = undefined opcode
//   alu_a/alu_b/alu_op    registered ALU inputs
//   alu_result/e/ge       ALU outputs
//   busy                  sequencer not idle
//   op_count              completed operations (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_e,
    output logic              rsp_ge,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_e,
    input  logic              alu_ge,
    output logic              busy,
    output logic [15:0]       op_count
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_rr_ptr;
    logic              r_owner;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_e;
    logic              r_rsp_ge;
    logic              r_rsp_err;
    logic [15:0]       r_op_count;

    logic [1:0]        w_grant;
    logic              w_grant_idx;
    logic              w_rsp_fire;

    // Grants are only offered in IDLE, and never while reset is asserted.
    alu_share_arb_rr_arb2 u_rr_arb2 (
        .en        ((r_state == ST_IDLE) && !rst),
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Only the owner's rsp_ready can complete the response.
    assign w_rsp_fire = (r_state == ST_RESP) && r_rsp_valid[r_owner] && rsp_ready[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_grant) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_fire) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= 1'(RR_INIT);
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_result <= '0;
            r_rsp_e      <= 1'b0;
            r_rsp_ge     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // ALU inputs only change on a grant so the ALU stays quiet.
                    if (|w_grant) begin
                        r_alu_a  <= w_grant_idx ? req1_a  : req0_a;
                        r_alu_b  <= w_grant_idx ? req1_b  : req0_b;
                        r_alu_op <= w_grant_idx ? req1_op : req0_op;
                        r_owner  <= w_grant_idx;
                        r_rr_ptr <= ~w_grant_idx;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result <= alu_result;
                    r_rsp_e      <= alu_e;
                    r_rsp_ge     <= alu_ge;
                    r_rsp_err    <= is_undef_op(4'(r_alu_op));
                    r_rsp_valid  <= r_owner ? 2'b10 : 2'b01;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 2'b00;
                        r_op_count  <= r_op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_e      = r_rsp_e;
    assign rsp_ge     = r_rsp_ge;
    assign rsp_err    = r_rsp_err;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign busy       = (r_state != ST_IDLE);
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester arbiter and sequencer that time-shares one combinational ALU (4-bit alu_op, 32-bit operands, E/GE flags) between requester 0 (integer pipeline execute stage) and requester 1 (branch/address helper unit).
- Owns the ALU operand/op inputs. Accepts one operation at a time over a valid/ready handshake, with round-robin priority.
- Registers the ALU outputs and returns result, E and GE to the requester that issued the operation.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, ALU opcode width.
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester operation valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept.
- req0_a, req0_b  input  DATA_W  requester 0 operands.
- req0_op  input  OP_W  requester 0 opcode.
- req1_a, req1_b  input  DATA_W  requester 1 operands.
- req1_op  input  OP_W  requester 1 opcode.
- rsp_valid  output  2  per-requester response valid.
- rsp_ready  input  2  per-requester response accept.
- rsp_result  output  DATA_W  captured ALU result.
- rsp_e, rsp_ge  output  1  captured E / GE flags.
- rsp_err  output  1  opcode was undefined.
- alu_a, alu_b  output  DATA_W  registered ALU operands.
- alu_op  output  OP_W  registered ALU opcode.
- alu_result  input  DATA_W  ALU result.
- alu_e, alu_ge  input  1  ALU flags.
- busy  output  1  state != IDLE.
- op_count  output  16  completed-operation counter.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE; rr_ptr=RR_INIT.
  - alu_a=0, alu_b=0, alu_op=0.
  - rsp_valid=0, rsp_result=0, rsp_e=0, rsp_ge=0, rsp_err=0.
  - op_count=0; req_ready=0 during the reset cycle.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational from req_valid and rr_ptr.
  - Only one valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - req_ready is one-hot or zero; it is never asserted outside IDLE.
  - Handshake = req_valid[i] & req_ready[i] at edge T. At T, register the granted a/b/op into alu_a/alu_b/alu_op, record owner=i, set rr_ptr=~i, go to EXEC.
- EXEC (cycle T+1):
  - ALU inputs are stable from registers. At the end of the cycle, capture alu_result/alu_e/alu_ge into the rsp_* registers.
  - rsp_err=1 when alu_op is in {3,4,13,14,15}; the captured result (0) is still forwarded.
  - Go to RESP.
- RESP (from cycle T+2):
  - rsp_valid[owner]=1; the other bit stays 0.
  - rsp_* and alu_* are held stable while waiting.
  - On rsp_valid[owner]&rsp_ready[owner]: clear rsp_valid, increment op_count, return to IDLE.
- Latency: response visible 2 cycles after the accept edge. Minimum issue interval is 3 cycles with zero-wait rsp_ready.
- rsp_ready of the non-owner is ignored. rsp_ready asserted before RESP has no effect.
- op_count wraps from 16'hFFFF to 0.
- rr_ptr changes only on a grant. A single-requester grant also flips it to the other side.
- A requester may deassert req_valid without a handshake and suffers no side effects. Operands are sampled only at the handshake edge.
- Reset mid-operation (EXEC or RESP): the in-flight operation is dropped, no response is produced, op_count is not incremented, and the block returns to IDLE.
- alu_* holds its last value in IDLE (no toggling), so the ALU flags stay quiet.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2), ALU opcode constants (OP_SLL=0, OP_SRA=1, OP_SRL=2, OP_ADD=5, OP_SUB=6, OP_AND=7, OP_OR=8, OP_XOR=9, OP_NOR=10, OP_SLT=11, OP_SLTU=12), and an undefined-opcode mask.
- Natural sub-module: rr_arb2, a combinational 2-way round-robin grant from req_valid and rr_ptr. Everything else stays in the top.

Test Plan:
- Single op: req0 a=5, b=3, op=5 with rsp_ready[0]=1 -> rsp_valid[0] 2 cycles after accept, rsp_result=8, rsp_e=0, rsp_ge=1, rsp_err=0, op_count=1.
- Contention: both valid from reset with RR_INIT=0, req1 op=6 a=7 b=7 -> req0 granted first, req1 second; req1 rsp_result=0, rsp_e=1, rsp_ge=1; next contention grants req0.
- Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1] and rsp_* stable, req_ready=2'b00 throughout, then completes on the first ready cycle.
- Undefined op: req0 op=13 -> rsp_result=0, rsp_err=1, op_count increments.
- Reset in EXEC: assert rst at T+1 -> no rsp_valid, op_count unchanged, state IDLE, a new request is accepted on the cycle after rst deasserts.
- Counter wrap: preload via 65536 back-to-back ops (or force) -> op_count goes 16'hFFFF -> 0.
